// File: rtl/low_power_booth_divider_pkg.sv
// Shared constants for the low-power signed divider: FSM encoding, power modes
// and per-iteration cost weights reported through power_consumption.
package div_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE    = 2'd0;
  localparam state_t COMPUTE = 2'd1;
  localparam state_t FINISH  = 2'd2;

  localparam logic [1:0] MODE_NORMAL = 2'b00;
  localparam logic [1:0] MODE_LP     = 2'b01;
  localparam logic [1:0] MODE_ULP    = 2'b10;

  localparam logic [7:0] COST_ACCEPT     = 8'd2;
  localparam logic [7:0] COST_REJECT     = 8'd1;
  localparam logic [7:0] COST_REJECT_ULP = 8'd0;

  // Reserved mode 11 is priced like normal mode.
  function automatic logic [7:0] reject_cost(input logic [1:0] mode);
    case (mode)
      MODE_ULP:             return COST_REJECT_ULP;
      MODE_NORMAL, MODE_LP: return COST_REJECT;
      default:              return COST_REJECT;
    endcase
  endfunction

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/low_power_booth_divider_if.sv
// Request/result bundle of the divider; mirrors the Booth multiplier handshake.
interface low_power_booth_divider_if #(parameter int W = 8);

  logic           start;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic [1:0]     power_mode;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic           done;
  logic           busy;
  logic           overflow;
  logic           div_by_zero;
  logic [7:0]     power_consumption;

  modport master (
    output start, dividend, divisor, power_mode,
    input  quotient, remainder, done, busy, overflow, div_by_zero, power_consumption
  );

  modport slave (
    input  start, dividend, divisor, power_mode,
    output quotient, remainder, done, busy, overflow, div_by_zero, power_consumption
  );

endinterface

// File: rtl/low_power_booth_divider_step.sv
// One restoring iteration: trial-subtract the divisor aligned to the current
// quotient bit position from the running residual.
module div_restore_step #(
  parameter int W = 8
) (
  input  logic [2*W-1:0]         residual,
  input  logic [W-1:0]           divisor_mag,
  input  logic [$clog2(W)-1:0]   count,
  output logic [2*W-1:0]         next_residual,
  output logic                   q_bit,
  output logic                   accept
);

  localparam int CW = $clog2(W);

  logic [CW-1:0]  shamt;
  logic [2*W-1:0] aligned;
  logic [2*W:0]   trial;

  always_comb begin
    shamt         = CW'(W - 1) - count;
    aligned       = {{W{1'b0}}, divisor_mag} << shamt;
    trial         = {1'b0, residual} - {1'b0, aligned};
    accept        = ~trial[2*W];
    q_bit         = accept;
    next_residual = accept ? trial[2*W-1:0] : residual;
  end

endmodule

// File: rtl/low_power_booth_divider.sv
// Sequential signed divider (2W / W -> W quotient, W remainder), one quotient
// bit per clock, with sign fix-up, overflow and divide-by-zero reporting.
module low_power_booth_divider
  import div_pkg::*;
#(
  parameter int W = 8
) (
  input logic                       clk,
  input logic                       reset,
  low_power_booth_divider_if.slave  bus
);

  localparam int CW = $clog2(W);

  state_t         state;
  logic [2*W-1:0] res_r;
  logic [W-1:0]   dvs_r;
  logic [W-1:0]   q_r;
  logic [CW-1:0]  count;
  logic [7:0]     cost_r;
  logic [1:0]     mode_r;
  logic           sign_n;
  logic           sign_d;
  logic           dbz_f;
  logic           ovf_f;

  logic [W-1:0]   quotient_r;
  logic [W-1:0]   remainder_r;
  logic           done_r;
  logic           overflow_r;
  logic           dbz_r;
  logic [7:0]     pc_r;

  logic [2*W-1:0] dvd_mag;
  logic [W-1:0]   dvs_mag;
  logic [2*W-1:0] next_res;
  logic           q_bit;
  logic           accept;
  logic           q_neg;
  logic           q_range_fail;
  logic [W-1:0]   q_signed;

  always_comb begin
    dvd_mag      = bus.dividend[2*W-1] ? -bus.dividend : bus.dividend;
    dvs_mag      = bus.divisor[W-1] ? -bus.divisor : bus.divisor;
    q_neg        = sign_n ^ sign_d;
    q_range_fail = q_neg ? (q_r[W-1] && (q_r[W-2:0] != '0)) : q_r[W-1];
    q_signed     = q_neg ? -q_r : q_r;
  end

  // The residual keeps the full 2W-bit dividend and subtracts the divisor shifted
  // into place, so a rejected trial leaves it untouched and its write can be gated.
  div_restore_step #(.W(W)) u_step (
    .residual      (res_r),
    .divisor_mag   (dvs_r),
    .count         (count),
    .next_residual (next_res),
    .q_bit         (q_bit),
    .accept        (accept)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      res_r       <= '0;
      dvs_r       <= '0;
      q_r         <= '0;
      count       <= '0;
      cost_r      <= '0;
      mode_r      <= '0;
      sign_n      <= 1'b0;
      sign_d      <= 1'b0;
      dbz_f       <= 1'b0;
      ovf_f       <= 1'b0;
      quotient_r  <= '0;
      remainder_r <= '0;
      done_r      <= 1'b0;
      overflow_r  <= 1'b0;
      dbz_r       <= 1'b0;
      pc_r        <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            sign_n <= bus.dividend[2*W-1];
            sign_d <= bus.divisor[W-1];
            mode_r <= bus.power_mode;
            dvs_r  <= dvs_mag;
            q_r    <= '0;
            count  <= '0;
            cost_r <= '0;
            dbz_f  <= 1'b0;
            ovf_f  <= 1'b0;
            if (bus.divisor == '0) begin
              // Raw dividend is kept so its low half can be returned as the remainder.
              res_r <= bus.dividend;
              dbz_f <= 1'b1;
              state <= FINISH;
            end else if (dvd_mag[2*W-1:W] >= dvs_mag) begin
              res_r <= dvd_mag;
              ovf_f <= 1'b1;
              state <= FINISH;
            end else begin
              res_r <= dvd_mag;
              state <= COMPUTE;
            end
          end
        end

        COMPUTE: begin
          if (accept || (mode_r != MODE_ULP)) begin
            res_r <= next_res;
          end
          q_r    <= {q_r[W-2:0], q_bit};
          cost_r <= sat_add(cost_r, accept ? COST_ACCEPT : reject_cost(mode_r));
          count  <= count + CW'(1);
          if (count == CW'(W - 1)) begin
            state <= FINISH;
          end
        end

        FINISH: begin
          done_r <= 1'b1;
          state  <= IDLE;
          if (dbz_f) begin
            quotient_r  <= '1;
            remainder_r <= res_r[W-1:0];
            overflow_r  <= 1'b0;
            dbz_r       <= 1'b1;
            pc_r        <= '0;
          end else if (ovf_f || q_range_fail) begin
            quotient_r  <= '0;
            remainder_r <= '0;
            overflow_r  <= 1'b1;
            dbz_r       <= 1'b0;
            pc_r        <= cost_r;
          end else begin
            quotient_r  <= q_signed;
            remainder_r <= sign_n ? -res_r[W-1:0] : res_r[W-1:0];
            overflow_r  <= 1'b0;
            dbz_r       <= 1'b0;
            pc_r        <= cost_r;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.quotient          = quotient_r;
  assign bus.remainder         = remainder_r;
  assign bus.done              = done_r;
  assign bus.busy              = (state != IDLE);
  assign bus.overflow          = overflow_r;
  assign bus.div_by_zero       = dbz_r;
  assign bus.power_consumption = pc_r;

endmodule

// File: doc/low_power_booth_divider.md
Name: low_power_booth_divider

Overview:
- Sequential signed divider that inverts the team's low-power Booth multiplier: 2W-bit dividend ÷ W-bit divisor → W-bit quotient + W-bit remainder.
- Shares the multiplier's start/done handshake, power_mode input and power_consumption report, so software can pair the two blocks.
- Core is restoring division on magnitudes, one quotient bit per clock, with sign fix-up and overflow / divide-by-zero detection.

Parameters:
- W, 8, operand width; dividend is 2W bits, divisor/quotient/remainder are W bits.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- dividend  in  2W  signed two's-complement dividend
- divisor  in  W  signed two's-complement divisor
- power_mode  in  2  00 normal, 01 low power, 10 ultra-low power, 11 reserved (treated as 00)
- quotient  out  W  signed quotient, truncated toward zero
- remainder  out  W  signed remainder; sign follows dividend
- done  out  1  one-cycle result-valid pulse
- busy  out  1  high while not IDLE
- overflow  out  1  quotient not representable in W signed bits
- div_by_zero  out  1  divisor was zero
- power_consumption  out  8  iteration-cost sum for the last operation

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high. On reset, every output and internal register is 0 and state is IDLE.
- States:
  - IDLE: start=1 latches |dividend|, |divisor|, both sign bits, power_mode, count=0 and cost=0.
    - If divisor==0: next state FINISH with dbz flag set.
    - Else if |dividend|[2W-1:W] >= |divisor|: next state FINISH with ovf flag set (unsigned pre-check).
    - Otherwise: next state COMPUTE.
  - COMPUTE: one restoring step per cycle. Shift partial remainder left by 1, bringing in the next dividend bit, MSB first. Trial-subtract |divisor|.
    - Trial result non-negative: write it back, quotient bit = 1, cost += 2.
    - Trial result negative: quotient bit = 0, cost += 1 in modes 00/01/11. In mode 10 the remainder register is not written (clock-enable suppressed) and cost += 0.
    - count increments each cycle; after count == W-1, go to FINISH.
  - FINISH (one cycle):
    - Negate quotient if the two signs differ; negate remainder if the dividend is negative.
    - Signed range check: a positive quotient must be <= 2^(W-1)-1; a negative quotient must be >= -2^(W-1). On failure set overflow.
    - Register outputs; done<=1 for exactly one cycle; state -> IDLE.
- Latency: start sampled at edge E0.
  - Normal operation: done visible after E(W+1), i.e. after E9 for W=8.
  - Early exit (dbz or pre-check ovf): done visible after E1.
- Error results:
  - div_by_zero: quotient = all ones, remainder = dividend[W-1:0], overflow=0, power_consumption=0.
  - overflow: quotient=0, remainder=0, div_by_zero=0. power_consumption is 0 on pre-check exit, or the accumulated cost on post-check failure.
- Output holding: quotient, remainder, overflow, div_by_zero and power_consumption hold until the next FINISH. done is 0 in all other cycles.
- Handshake:
  - start while busy is ignored; the in-flight operation is unaffected.
  - start in the same cycle as FINISH is ignored, because the FSM is not in IDLE.
  - Back-to-back: start may be asserted the cycle after done.
- Inputs: dividend, divisor and power_mode are used only at the start edge; later changes have no effect.
- Magnitudes: |dividend| uses 2W-bit unsigned, so -2^(2W-1) is legal. |divisor| uses W-bit unsigned, so -2^(W-1) is legal.
- Mid-operation reset: abort, no done pulse, all outputs cleared.
- power_consumption saturates at 255 (unreachable for W<=8).

Decomposition:
- Package div_pkg holds:
  - state encoding IDLE/COMPUTE/FINISH
  - power_mode constants MODE_NORMAL / MODE_LP / MODE_ULP
  - cost constants COST_ACCEPT=2, COST_REJECT=1, COST_REJECT_ULP=0
- One sub-module, div_restore_step: combinational shift + trial subtract, returning the next remainder, the quotient bit and an accept flag.

Test Plan:
- Mode 00, 100 / 7 -> quotient 14 (0x0E), remainder 2, done after 9 edges, power_consumption 11 (3 accepts, 5 rejects); mode 10 same operands -> power_consumption 6.
- Mode 01, -100 / 7 -> quotient 0xF2 (-14), remainder 0xFE (-2); -100 / -7 -> quotient 14, remainder 0xFE; no flags set.
- -384 / 3 -> quotient 0x80 (-128), remainder 0, overflow 0, power_consumption 9. 384 / 3 -> overflow 1, quotient 0, remainder 0, done after 9 edges (post-check).
- 1000 / 3 -> overflow 1 via pre-check, done after 1 edge, power_consumption 0. 1234 / 0 -> div_by_zero 1, quotient 0xFF, remainder 0xD2, done after 1 edge.
- start pulsed again while busy with changed operands -> ignored; first result correct, exactly one done. reset asserted at iteration 4 -> no done, all outputs 0, next start works normally.
